// File: rtl/if_decision_arbiter_if.sv
// Requester-side bundle for if_decision_arbiter: decision inputs, grant handshake
// and the debug violation counters.
interface if_decision_arbiter_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8
);
  logic [1:0]    mode;
  logic          else_en;
  logic          eval;
  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic          gnt_else;
  logic          err_multi;
  logic          err_none;
  logic [CW-1:0] multi_cnt;
  logic [CW-1:0] none_cnt;

  modport master (
    output mode, else_en, eval, req, done,
    input  gnt, gnt_valid, gnt_else, err_multi, err_none, multi_cnt, none_cnt
  );

  modport slave (
    input  mode, else_en, eval, req, done,
    output gnt, gnt_valid, gnt_else, err_multi, err_none, multi_cnt, none_cnt
  );
endinterface

// File: rtl/if_decision_arbiter.sv
// Evaluates priority/unique/unique0 if-rules on a request vector, grants the first
// true condition until done, and reports/counts qualifier violations.
module if_decision_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8
) (
  input logic                clk,
  input logic                rst_n,
  if_decision_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [N-1:0]  ReqOne = N'(1);
  localparam logic [CW-1:0] CntOne = CW'(1);
  localparam logic [CW-1:0] CntMax = '1;

  state_e        state_q;
  logic [N-1:0]  gnt_q;
  logic          gnt_valid_q;
  logic          gnt_else_q;
  logic          err_multi_q;
  logic          err_none_q;
  logic [CW-1:0] multi_cnt_q;
  logic [CW-1:0] none_cnt_q;

  logic [N-1:0] req_lsb;
  logic         any_hit;
  logic         multi_hit;
  logic         is_strict;
  logic         is_unique0;
  logic         set_multi;
  logic         set_none;

  always_comb begin
    // Isolate the lowest set bit: x & -x.
    req_lsb    = bus.req & (~bus.req + ReqOne);
    any_hit    = |bus.req;
    multi_hit  = |(bus.req & (bus.req - ReqOne));
    is_strict  = (bus.mode == 2'd1) || (bus.mode == 2'd2);
    is_unique0 = (bus.mode == 2'd2);
    set_multi  = multi_hit && is_strict;
    // Reserved mode 3 falls in with priority: reports no-match.
    set_none   = !any_hit && !bus.else_en && !is_unique0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_else_q  <= 1'b0;
      err_multi_q <= 1'b0;
      err_none_q  <= 1'b0;
      multi_cnt_q <= '0;
      none_cnt_q  <= '0;
    end else begin
      gnt_else_q  <= 1'b0;
      err_multi_q <= 1'b0;
      err_none_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.eval) begin
            if (any_hit) begin
              gnt_q       <= req_lsb;
              gnt_valid_q <= 1'b1;
              state_q     <= StGrant;
            end else if (bus.else_en) begin
              gnt_else_q <= 1'b1;
            end
            err_multi_q <= set_multi;
            err_none_q  <= set_none;
            if (set_multi && (multi_cnt_q != CntMax)) multi_cnt_q <= multi_cnt_q + CntOne;
            if (set_none && (none_cnt_q != CntMax)) none_cnt_q <= none_cnt_q + CntOne;
          end
        end
        StGrant: begin
          if (bus.done) begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_else  = gnt_else_q;
  assign bus.err_multi = err_multi_q;
  assign bus.err_none  = err_none_q;
  assign bus.multi_cnt = multi_cnt_q;
  assign bus.none_cnt  = none_cnt_q;

endmodule

// File: tb/tb_if_decision_arbiter.sv
// Scoreboard bench for if_decision_arbiter (N=4, CW=2 so saturation is reachable).
module tb_if_decision_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_decision_arbiter_if #(.N(N), .CW(CW)) bus ();

  if_decision_arbiter #(.N(N), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic          vld;
    logic          els;
    logic          mul;
    logic          non;
    logic [CW-1:0] mc;
    logic [CW-1:0] nc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  logic          m_grant = 1'b0;
  logic [N-1:0]  m_gnt   = '0;
  logic [CW-1:0] m_mc    = '0;
  logic [CW-1:0] m_nc    = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".gnt"},       32'(bus.gnt),       32'(e.gnt));
    check({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(e.vld));
    check({tag, ".gnt_else"},  32'(bus.gnt_else),  32'(e.els));
    check({tag, ".err_multi"}, 32'(bus.err_multi), 32'(e.mul));
    check({tag, ".err_none"},  32'(bus.err_none),  32'(e.non));
    check({tag, ".multi_cnt"}, 32'(bus.multi_cnt), 32'(e.mc));
    check({tag, ".none_cnt"},  32'(bus.none_cnt),  32'(e.nc));
  endtask

  task automatic step(input string tag, input logic [1:0] mode, input logic else_en,
                      input logic [N-1:0] req, input logic eval, input logic done);
    exp_t e;
    int   pc;
    logic [N-1:0] low;
    @(negedge clk);
    bus.mode = mode; bus.else_en = else_en; bus.req = req; bus.eval = eval; bus.done = done;
    e = '0;
    if (!m_grant && eval) begin
      pc  = 0;
      low = '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          pc++;
          low = '0;
          low[i] = 1'b1;
        end
      end
      if (pc > 0) begin
        m_grant = 1'b1;
        m_gnt   = low;
      end else if (else_en) begin
        e.els = 1'b1;
      end
      e.mul = (pc > 1) && (mode == 2'd1 || mode == 2'd2);
      e.non = (pc == 0) && !else_en && (mode != 2'd2);
      if (e.mul && m_mc != '1) m_mc = m_mc + 1'b1;
      if (e.non && m_nc != '1) m_nc = m_nc + 1'b1;
    end else if (m_grant && done) begin
      m_grant = 1'b0;
      m_gnt   = '0;
    end
    e.gnt = m_gnt; e.vld = m_grant; e.mc = m_mc; e.nc = m_nc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_all(tag, sb.pop_front());
  endtask

  initial begin
    bus.mode = 2'd0; bus.else_en = 1'b0; bus.req = '0; bus.eval = 1'b0; bus.done = 1'b0;
    #2;
    check_all("reset", exp_t'(0));
    #10 rst_n = 1'b1;

    step("prio_ovl",  2'd0, 1'b0, 4'b0110, 1'b1, 1'b0);
    step("prio_done", 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1);

    step("uniq_ovl",   2'd1, 1'b0, 4'b1100, 1'b1, 1'b0);
    step("uniq_hold",  2'd1, 1'b0, 4'b1100, 1'b0, 1'b0);
    step("uniq_done",  2'd1, 1'b0, 4'b0000, 1'b0, 1'b1);
    step("uniq_none",  2'd1, 1'b0, 4'b0000, 1'b1, 1'b0);
    step("uniq_idle",  2'd1, 1'b0, 4'b0000, 1'b0, 1'b0);

    step("u0_silent",  2'd2, 1'b0, 4'b0000, 1'b1, 1'b0);
    step("u0_ovl",     2'd2, 1'b0, 4'b1010, 1'b1, 1'b0);
    step("u0_done",    2'd2, 1'b0, 4'b0000, 1'b0, 1'b1);

    step("else",       2'd1, 1'b1, 4'b0000, 1'b1, 1'b0);
    step("else_end",   2'd1, 1'b1, 4'b0000, 1'b0, 1'b0);

    step("hold_gnt",   2'd0, 1'b0, 4'b1000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      step("hold", 2'($urandom_range(0, 3)), 1'b0, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
    step("done_eval",  2'd1, 1'b0, 4'b1111, 1'b1, 1'b1);
    step("after_rel",  2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
    step("done_idle",  2'd0, 1'b0, 4'b0100, 1'b0, 1'b1);

    step("rsvd_none",  2'd3, 1'b0, 4'b0000, 1'b1, 1'b0);
    step("rsvd_ovl",   2'd3, 1'b0, 4'b0110, 1'b1, 1'b0);
    step("rsvd_done",  2'd3, 1'b0, 4'b0000, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++) begin
      step("sat_eval", 2'd1, 1'b0, 4'b0011, 1'b1, 1'b0);
      step("sat_done", 2'd1, 1'b0, 4'b0000, 1'b0, 1'b1);
    end

    step("pre_rst", 2'd0, 1'b0, 4'b0100, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all("async_rst", exp_t'(0));
    m_grant = 1'b0; m_gnt = '0; m_mc = '0; m_nc = '0;
    #1 rst_n = 1'b1;
    step("post_rst", 2'd1, 1'b0, 4'b0101, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_decision_arbiter.md
# if_decision_arbiter

- Hardware decision block that executes the `priority if` / `unique if` / `unique0 if` rules on a request vector.
- On an evaluate strobe it picks the first true condition (lowest-index request), or the `else` branch if one exists.
- In the same cycle it raises the violation that the selected qualifier would report: multiple matches, or no match with no `else`.
- It sits between requesters and a shared resource. The grant is held until a done handshake, and saturating violation counters are exposed for debug and regression checks.

## Interface
- N, 4, number of request lines (conditions); 2..16
- CW, 8, width of each violation counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  qualifier: 0 priority, 1 unique, 2 unique0, 3 reserved (treated as priority)
- else_en  in  1  1 = an else branch exists
- eval  in  1  evaluate strobe; sampled in IDLE only
- req  in  N  condition vector; bit 0 is the first condition
- done  in  1  requester releases the current grant
- gnt  out  N  one-hot grant; 0 when not granting
- gnt_valid  out  1  a grant is held
- gnt_else  out  1  one-cycle pulse: the else branch was taken
- err_multi  out  1  one-cycle pulse: overlap violation
- err_none  out  1  one-cycle pulse: no-match violation
- multi_cnt  out  CW  saturating count of err_multi pulses
- none_cnt  out  CW  saturating count of err_none pulses

## Operation
- FSM with two states, IDLE and GRANT. Reset state is IDLE.
- In IDLE, with eval=1: sample mode, else_en and req, then decide:
  - **req != 0:** grant the lowest set bit. Set gnt to that one-hot value and gnt_valid=1, and go to GRANT.
  - **req == 0, else_en=1:** pulse gnt_else and stay in IDLE.
  - **req == 0, else_en=0:** no grant; stay in IDLE.
- err_multi pulses when popcount(req) > 1 and mode is unique or unique0. In priority mode an overlap is legal.
- err_none pulses when req == 0, else_en=0, and mode is priority or unique. In unique0 mode a no-match is silent.
- Priority-order selection is identical in all modes. Only error reporting differs.
- An error pulse may coincide with a grant. Example: unique mode with req=0110 grants bit 1 and pulses err_multi.
- In GRANT:
  - gnt and gnt_valid hold; req and mode changes are ignored.
  - eval is ignored: no decision, no errors.
  - done=1 returns the FSM to IDLE.
- eval asserted in the same cycle that done releases a grant is ignored. A new evaluation needs eval high while in IDLE.
- done in IDLE is ignored.
- Counters increment by 1 on each pulse and saturate at 2^CW-1; they never wrap.
- Reset clears every output and counter at any point, including mid-grant.

## Timing
- **Reset values (asynchronous on rst_n low):** gnt=0, gnt_valid=0, gnt_else=0, err_multi=0, err_none=0, multi_cnt=0, none_cnt=0, state IDLE.
- **Decision latency:** for eval high at rising edge k in IDLE, gnt, gnt_valid, gnt_else and the error pulses are all valid after edge k. They are registered outputs, visible in cycle k+1.
- **Counters:** update at the same edge as their error pulse.
- **Pulse width:** gnt_else, err_multi and err_none are high for exactly one cycle.
- **Release latency:** done high at edge m in GRANT drops gnt and gnt_valid after edge m.
- **Back-to-back throughput:** a new grant can be issued by eval at edge m+1 at the earliest. Throughput is one grant per 2 cycles.
- **Reset release:** rst_n deasserts asynchronously to the design. The first eval is honoured at the first rising edge with rst_n high.

## Test plan
- **Priority overlap:** mode=0, else_en=0, req=0110, eval -> gnt=0010, gnt_valid=1, err_multi=0, err_none=0. Then done -> gnt=0 one cycle later.
- **Unique overlap and no-match:**
  - mode=1, req=1100, eval -> gnt=0100 and a one-cycle err_multi; multi_cnt=1.
  - After done: req=0000, else_en=0, eval -> err_none pulse; none_cnt=1; gnt_valid stays 0.
- **Unique0 silence:** mode=2, req=0000, else_en=0, eval -> no error pulses, counters unchanged. Then req=1010, eval -> gnt=0010 and err_multi pulse.
- **Else branch:** mode=1, req=0000, else_en=1, eval -> gnt_else one-cycle pulse, err_none=0, state stays IDLE.
- **Grant hold:** while in GRANT, toggle req and pulse eval for 5 cycles -> gnt unchanged, no error pulses. done together with eval -> release only, no new grant.
- **Saturation and reset:**
  - CW=2, mode=1: 5 overlapping evals (each followed by done) -> multi_cnt stops at 3.
  - Assert rst_n=0 mid-grant -> all outputs 0 immediately, without waiting for a clock edge.
